// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin scheduler sharing one byte UART TX between 16-bit requesters
// Optional: define UART_TX_SCHED_PRIO_EN to give requester 0 strict priority.
module uart_tx_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int GAP_CYCLES = 1000,
   parameter int IDW        = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [16*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic [IDW-1:0]        grant_id
);

   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

   typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI, GAP} state_t;

   state_t         state, state_nx;
   logic [7:0]     word_hi, word_hi_nx, tx_data_nx;
   logic           tx_valid_nx;
   logic [IDW-1:0] grant_nx, rr_ptr, rr_nx, sel, ix;
   logic [GW-1:0]  gap_cnt, gap_nx;
   logic           found, prio_win;
   int             idx;

   // Search starts just after the last round-robin winner, wrapping modulo NUM_REQ.
   always_comb begin
      found    = 1'b0;
      prio_win = 1'b0;
      sel      = '0;
      idx      = 0;
      ix       = '0;
`ifdef UART_TX_SCHED_PRIO_EN
      if (req_valid[0]) begin
         found    = 1'b1;
         prio_win = 1'b1;
      end
`endif
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         ix = IDW'(idx);
         if (!found && req_valid[ix]) begin
            found = 1'b1;
            sel   = ix;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == IDLE && found) req_ready[sel] = 1'b1;
   end

   assign busy = (state != IDLE);

   always_comb begin
      state_nx    = state;
      word_hi_nx  = word_hi;
      tx_data_nx  = tx_data;
      tx_valid_nx = tx_valid;
      grant_nx    = grant_id;
      rr_nx       = rr_ptr;
      gap_nx      = gap_cnt;
      case (state)
         IDLE: begin
            if (found) begin
               word_hi_nx  = req_data[16*sel+8 +: 8];
               tx_data_nx  = req_data[16*sel +: 8];
               tx_valid_nx = 1'b1;
               grant_nx    = sel;
               if (!prio_win) rr_nx = sel;
               state_nx    = SEND_LO;
            end
         end
         SEND_LO: begin
            if (tx_ready) begin
               tx_data_nx = word_hi;
               state_nx   = SEND_HI;
            end
         end
         SEND_HI: begin
            if (tx_ready) begin
               tx_valid_nx = 1'b0;
               if (GAP_CYCLES > 0) begin
                  gap_nx   = GAP_LOAD;
                  state_nx = GAP;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         GAP: begin
            if (gap_cnt == '0) state_nx = IDLE;
            else               gap_nx   = gap_cnt - 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_hi  <= '0;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         grant_id <= '0;
         rr_ptr   <= IDW'(NUM_REQ - 1);
         gap_cnt  <= '0;
      end else begin
         word_hi  <= word_hi_nx;
         tx_data  <= tx_data_nx;
         tx_valid <= tx_valid_nx;
         grant_id <= grant_nx;
         rr_ptr   <= rr_nx;
         gap_cnt  <= gap_nx;
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - scoreboard bench for uart_tx_scheduler (GAP_CYCLES=4 and GAP_CYCLES=0 instances)
module tb_uart_tx_scheduler;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [3:0]  req_valid, req_ready;
   logic [63:0] req_data;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready, busy;
   logic [1:0]  grant_id;

   logic [3:0]  b_req_valid, b_req_ready;
   logic [63:0] b_req_data;
   logic [7:0]  b_tx_data;
   logic        b_tx_valid, b_tx_ready, b_busy;
   logic [1:0]  b_grant_id;

   int total = 0, bad = 0, cyc = 0;
   int acc_cnt = 0, b_acc_cnt = 0, b_last_acc = -1;
   logic [7:0] exp_bytes[$], b_exp_bytes[$];
   int         exp_grants[$], b_exp_grants[$];

   uart_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(4), .IDW(2)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .grant_id(grant_id));

   uart_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(0), .IDW(2)) u_dut_nogap (
      .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_data(b_req_data), .req_ready(b_req_ready),
      .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .busy(b_busy), .grant_id(b_grant_id));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic int oh_idx(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst) begin
         if (tx_valid && tx_ready) begin
            if (exp_bytes.size() == 0) chk("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
            else                       chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_bytes.pop_front()});
         end
         if ((req_ready & req_valid) != 4'd0) begin
            chk("ready_onehot", $countones(req_ready), 1);
            if (exp_grants.size() == 0) chk("unexpected_grant", oh_idx(req_ready), 32'hFFFF_FFFF);
            else                        chk("grant", oh_idx(req_ready), exp_grants.pop_front());
            acc_cnt++;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         if (b_tx_valid && b_tx_ready) begin
            if (b_exp_bytes.size() == 0) chk("b_unexpected_byte", {24'd0, b_tx_data}, 32'hFFFF_FFFF);
            else                         chk("b_tx_byte", {24'd0, b_tx_data}, {24'd0, b_exp_bytes.pop_front()});
         end
         if ((b_req_ready & b_req_valid) != 4'd0) begin
            if (b_exp_grants.size() == 0) chk("b_unexpected_grant", oh_idx(b_req_ready), 32'hFFFF_FFFF);
            else                          chk("b_grant", oh_idx(b_req_ready), b_exp_grants.pop_front());
            if (b_last_acc >= 0) chk("b_accept_spacing", cyc - b_last_acc, 3);
            b_last_acc = cyc;
            b_acc_cnt++;
         end
      end
   end

   task automatic wait_acc(input int target);
      int n = 0;
      while (acc_cnt < target && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk("accept_timeout", acc_cnt >= target, 1);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || tx_valid) && n < 200);
      chk("idle_timeout", n < 200, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int gc, n, sb;
      rst = 1'b0; req_valid = '0; req_data = '0; tx_ready = 1'b0;
      b_req_valid = '0; b_req_data = '0; b_tx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_req_ready", req_ready, 0);
      @(posedge clk);
      #1 rst = 1'b1;

      // single word, then exact GAP length
      exp_grants.push_back(0);
      exp_bytes.push_back(8'h5A); exp_bytes.push_back(8'hA5);
      tx_ready = 1'b1; req_data[15:0] = 16'hA55A; req_valid = 4'b0001;
      wait_acc(1);
      @(negedge clk);
      chk("ready_after_accept", req_ready, 0);
      chk("tx_valid_latency", tx_valid, 1);
      @(posedge clk);
      #1 req_valid = '0;
      n = 0;
      while (tx_valid && n < 50) begin @(negedge clk); n++; end
      gc = 0;
      while (busy && gc < 50) begin gc++; @(negedge clk); end
      chk("gap_busy_cycles", gc, 4);
      @(posedge clk);
      #1;

      // all four held from reset: 0,1,2,3,0
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      req_data = {16'h3333, 16'h2222, 16'h1111, 16'h0100};
      foreach (exp_grants[i]) ;
      exp_grants.push_back(0); exp_grants.push_back(1); exp_grants.push_back(2);
      exp_grants.push_back(3); exp_grants.push_back(0);
      exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h01);
      exp_bytes.push_back(8'h11); exp_bytes.push_back(8'h11);
      exp_bytes.push_back(8'h22); exp_bytes.push_back(8'h22);
      exp_bytes.push_back(8'h33); exp_bytes.push_back(8'h33);
      exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h01);
      req_valid = 4'b1111;
      wait_acc(6);
      req_valid = '0;
      wait_idle();

      // stall in SEND_LO for 20 cycles
      tx_ready = 1'b0;
      req_data[47:32] = 16'hBEEF; req_valid = 4'b0100;
      exp_grants.push_back(2);
      exp_bytes.push_back(8'hEF); exp_bytes.push_back(8'hBE);
      wait_acc(7);
      req_valid = '0;
      sb = 0;
      repeat (20) begin
         @(negedge clk);
         if (!(tx_valid && tx_data == 8'hEF && grant_id == 2'd2)) sb++;
      end
      chk("stall_stable", sb, 0);
      @(posedge clk);
      #1 tx_ready = 1'b1;
      wait_idle();

      // reset during SEND_HI aborts the high byte; rr_ptr returns to 3
      req_data[31:16] = 16'hC3D4; req_valid = 4'b0010;
      exp_grants.push_back(1);
      exp_bytes.push_back(8'hD4);
      wait_acc(8);
      req_valid = '0;
      @(posedge clk);
      #1 tx_ready = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("abort_tx_valid", tx_valid, 0);
      chk("abort_tx_data", tx_data, 0);
      chk("abort_busy", busy, 0);
      chk("abort_grant_id", grant_id, 0);
      chk("abort_req_ready", req_ready, 0);
      @(posedge clk);
      #1 tx_ready = 1'b1;
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      req_data[15:0] = 16'h1234; req_valid = 4'b0111;
      exp_grants.push_back(0);
      exp_bytes.push_back(8'h34); exp_bytes.push_back(8'h12);
      wait_acc(9);
      req_valid = '0;
      wait_idle();

      // GAP_CYCLES=0 instance: back-to-back words every 3 cycles
      b_tx_ready = 1'b1;
      b_req_data[31:0] = {16'hC3D4, 16'hA1B2};
      b_exp_grants.push_back(0); b_exp_grants.push_back(1); b_exp_grants.push_back(0);
      b_exp_bytes.push_back(8'hB2); b_exp_bytes.push_back(8'hA1);
      b_exp_bytes.push_back(8'hD4); b_exp_bytes.push_back(8'hC3);
      b_exp_bytes.push_back(8'hB2); b_exp_bytes.push_back(8'hA1);
      b_req_valid = 4'b0011;
      n = 0;
      while (b_acc_cnt < 3 && n < 200) begin @(posedge clk); n++; end
      chk("b_accept_timeout", b_acc_cnt >= 3, 1);
      #1 b_req_valid = '0;
      repeat (10) @(posedge clk);
      #1;
      chk("b_idle", b_busy, 0);
      chk("bytes_drained", exp_bytes.size(), 0);
      chk("grants_drained", exp_grants.size(), 0);
      chk("b_bytes_drained", b_exp_bytes.size(), 0);
      chk("b_grants_drained", b_exp_grants.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
